// File: rtl/sap_mem_pkg.sv
// Shared types and default sizes for the SAP program/data RAM access path.
package sap_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    localparam int SAP_AW       = 4;
    localparam int SAP_DW       = 8;
    localparam int SAP_MAX_WAIT = 3;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of arbitrations the loader has lost; at_limit forces a loader win.
module starve_counter #(
    parameter int CW    = 2,
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic clr_cnt,
    output logic at_limit
);

    logic [CW-1:0] count;

    assign at_limit = (count >= CW'(LIMIT));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (clr_cnt) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates the single-port RAM between CPU fetch/operand reads and the loader port.
// Build option WRITE_GUARD_EN: blocks loader writes unless the CPU is halted and flags ldr_err.
module ram_access_arbiter
    import sap_mem_pkg::*;
#(
    parameter int AW       = SAP_AW,
    parameter int DW       = SAP_DW,
    parameter int MAX_WAIT = SAP_MAX_WAIT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_rvalid,
`ifdef WRITE_GUARD_EN
    input  logic          cpu_halted,
    output logic          ldr_err,
`endif
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    arb_state_t state;
    owner_t     owner;
    logic       ldr_rd;
    logic       at_limit;
    logic       arb;
    logic       pick_ldr;
    logic       ldr_wr_ok;

    assign arb      = (state == IDLE) && (cpu_req || ldr_req);
    assign pick_ldr = ldr_req && (!cpu_req || at_limit);

`ifdef WRITE_GUARD_EN
    logic guard_hit;
    assign ldr_wr_ok = ldr_we && cpu_halted;
`else
    assign ldr_wr_ok = ldr_we;
`endif

    starve_counter #(
        .CW    (CW),
        .LIMIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .clr      (clr),
        .inc      (arb && cpu_req && ldr_req && !at_limit),
        .clr_cnt  (arb && pick_ldr),
        .at_limit (at_limit)
    );

    // Gated by clr so every output reads 0 while reset is held.
    assign cpu_stall = clr && cpu_req && !cpu_rvalid;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            ldr_rd     <= 1'b0;
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
`ifdef WRITE_GUARD_EN
            guard_hit  <= 1'b0;
            ldr_err    <= 1'b0;
`endif
        end else begin
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
`ifdef WRITE_GUARD_EN
            ldr_err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (arb) begin
                        state <= ACC;
                        if (pick_ldr) begin
                            owner     <= OWN_LDR;
                            ldr_gnt   <= 1'b1;
                            ldr_rd    <= !ldr_we;
                            ram_addr  <= ldr_addr;
                            ram_wdata <= ldr_wdata;
                            ram_we    <= ldr_wr_ok;
                            ram_re    <= !ldr_we;
`ifdef WRITE_GUARD_EN
                            guard_hit <= ldr_we && !cpu_halted;
`endif
                        end else begin
                            owner     <= OWN_CPU;
                            cpu_gnt   <= 1'b1;
                            ldr_rd    <= 1'b0;
                            ram_addr  <= cpu_addr;
                            ram_re    <= 1'b1;
`ifdef WRITE_GUARD_EN
                            guard_hit <= 1'b0;
`endif
                        end
                    end
                end
                ACC: begin
                    state <= RESP;
`ifdef WRITE_GUARD_EN
                    ldr_err <= guard_hit;
`endif
                end
                RESP: begin
                    // RAM data for the ACC-cycle read is valid now.
                    state <= IDLE;
                    if (owner == OWN_CPU) begin
                        cpu_rdata  <= ram_rdata;
                        cpu_rvalid <= 1'b1;
                    end else if (ldr_rd) begin
                        ldr_rdata  <= ram_rdata;
                        ldr_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
